// File: rtl/bsg_manycore_proc_endpoint.sv
// Processor-side endpoint of a manycore mesh node: buffered fwd/rev inputs, credit-gated requests.
// Optional credit-overflow checking is enabled by defining BSG_MANYCORE_ENDPOINT_CREDIT_CHECK_EN.
module bsg_manycore_proc_endpoint #(
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 4,
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 28,
    parameter int fifo_els_p        = 2,
    parameter int max_out_credits_p = 16,
    localparam int packet_width_lp = 2 + (data_width_p / 8) + addr_width_p + data_width_p
                                     + 2 * (x_cord_width_p + y_cord_width_p),
    localparam int return_packet_width_lp = 2 + data_width_p + x_cord_width_p + y_cord_width_p,
    localparam int link_sif_width_lp = packet_width_lp + return_packet_width_lp + 4,
    localparam int credit_width_lp = $clog2(max_out_credits_p + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [link_sif_width_lp-1:0]      link_sif_i,
    output logic [link_sif_width_lp-1:0]      link_sif_o,
    output logic                              in_v_o,
    output logic [packet_width_lp-1:0]        in_packet_o,
    input  logic                              in_yumi_i,
    input  logic                              returning_v_i,
    input  logic [return_packet_width_lp-1:0] returning_packet_i,
    output logic                              returning_ready_o,
    input  logic                              out_v_i,
    input  logic [packet_width_lp-1:0]        out_packet_i,
    output logic                              out_ready_o,
    output logic                              returned_v_o,
    output logic [return_packet_width_lp-1:0] returned_packet_o,
    input  logic                              returned_yumi_i,
    output logic [credit_width_lp-1:0]        out_credits_o,
    output logic                              credit_err_o
);

    typedef struct packed {
        logic                       v;
        logic [packet_width_lp-1:0] data;
        logic                       ready_and_rev;
    } fwd_s;

    typedef struct packed {
        logic                              v;
        logic [return_packet_width_lp-1:0] data;
        logic                              ready_and_rev;
    } rev_s;

    typedef struct packed {
        fwd_s fwd;
        rev_s rev;
    } link_s;

    localparam int ptr_width_lp = $clog2(fifo_els_p);
    localparam int cnt_width_lp = $clog2(fifo_els_p + 1);
    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);
    localparam logic [cnt_width_lp-1:0] fifo_full_cnt_lp = cnt_width_lp'(fifo_els_p);

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        if (p == ptr_width_lp'(fifo_els_p - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    link_s link_in, link_out;
    assign link_in    = link_sif_i;
    assign link_sif_o = link_out;

    // ---------------- fwd-in FIFO ----------------
    logic [packet_width_lp-1:0] fin_mem_q [fifo_els_p];
    logic [packet_width_lp-1:0] fin_mem_d [fifo_els_p];
    logic [ptr_width_lp-1:0]    fin_wptr_q, fin_wptr_d, fin_rptr_q, fin_rptr_d;
    logic [cnt_width_lp-1:0]    fin_cnt_q, fin_cnt_d;
    logic                       fin_full, fin_empty, fin_enq, fin_deq;

    assign fin_full  = (fin_cnt_q == fifo_full_cnt_lp);
    assign fin_empty = (fin_cnt_q == '0);
    assign fin_enq   = link_in.fwd.v & ~fin_full;
    assign fin_deq   = in_yumi_i & ~fin_empty;

    always_comb begin
        fin_mem_d  = fin_mem_q;
        fin_wptr_d = fin_wptr_q;
        fin_rptr_d = fin_rptr_q;
        fin_cnt_d  = fin_cnt_q;
        if (fin_enq) begin
            fin_mem_d[fin_wptr_q] = link_in.fwd.data;
            fin_wptr_d            = ptr_inc(fin_wptr_q);
        end
        if (fin_deq) begin
            fin_rptr_d = ptr_inc(fin_rptr_q);
        end
        if (fin_enq && !fin_deq) begin
            fin_cnt_d = fin_cnt_q + 1'b1;
        end else if (!fin_enq && fin_deq) begin
            fin_cnt_d = fin_cnt_q - 1'b1;
        end
    end

    // ---------------- rev-in FIFO ----------------
    logic [return_packet_width_lp-1:0] rin_mem_q [fifo_els_p];
    logic [return_packet_width_lp-1:0] rin_mem_d [fifo_els_p];
    logic [ptr_width_lp-1:0]           rin_wptr_q, rin_wptr_d, rin_rptr_q, rin_rptr_d;
    logic [cnt_width_lp-1:0]           rin_cnt_q, rin_cnt_d;
    logic                              rin_full, rin_empty, rin_enq, rin_deq;

    assign rin_full  = (rin_cnt_q == fifo_full_cnt_lp);
    assign rin_empty = (rin_cnt_q == '0);
    assign rin_enq   = link_in.rev.v & ~rin_full;
    assign rin_deq   = returned_yumi_i & ~rin_empty;

    always_comb begin
        rin_mem_d  = rin_mem_q;
        rin_wptr_d = rin_wptr_q;
        rin_rptr_d = rin_rptr_q;
        rin_cnt_d  = rin_cnt_q;
        if (rin_enq) begin
            rin_mem_d[rin_wptr_q] = link_in.rev.data;
            rin_wptr_d            = ptr_inc(rin_wptr_q);
        end
        if (rin_deq) begin
            rin_rptr_d = ptr_inc(rin_rptr_q);
        end
        if (rin_enq && !rin_deq) begin
            rin_cnt_d = rin_cnt_q + 1'b1;
        end else if (!rin_enq && rin_deq) begin
            rin_cnt_d = rin_cnt_q - 1'b1;
        end
    end

    // ---------------- credits and outgoing paths ----------------
    logic [credit_width_lp-1:0] credits_q, credits_d, credits_eff;
    logic                       send_fire;

    // Outputs show the reset state while reset is held; no injection happens during reset.
    assign credits_eff = reset_n_i ? credits_q : max_credits_lp;
    assign out_ready_o = reset_n_i & link_in.fwd.ready_and_rev & (credits_eff != '0);
    assign send_fire   = out_v_i & out_ready_o;

    always_comb begin
        credits_d = credits_q;
        if (send_fire && !rin_enq && credits_q != '0) begin
            credits_d = credits_q - 1'b1;
        end else if (rin_enq && !send_fire && credits_q != max_credits_lp) begin
            credits_d = credits_q + 1'b1;
        end
    end

    always_comb begin
        link_out.fwd.v             = reset_n_i & out_v_i & (credits_eff != '0);
        link_out.fwd.data          = out_packet_i;
        link_out.fwd.ready_and_rev = ~fin_full | ~reset_n_i;
        link_out.rev.v             = returning_v_i;
        link_out.rev.data          = returning_packet_i;
        link_out.rev.ready_and_rev = ~rin_full | ~reset_n_i;
    end

    assign returning_ready_o = link_in.rev.ready_and_rev;
    assign in_v_o            = reset_n_i & ~fin_empty;
    assign in_packet_o       = fin_mem_q[fin_rptr_q];
    assign returned_v_o      = reset_n_i & ~rin_empty;
    assign returned_packet_o = rin_mem_q[rin_rptr_q];
    assign out_credits_o     = credits_eff;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            fin_wptr_q <= '0;
            fin_rptr_q <= '0;
            fin_cnt_q  <= '0;
            rin_wptr_q <= '0;
            rin_rptr_q <= '0;
            rin_cnt_q  <= '0;
            credits_q  <= max_credits_lp;
        end else begin
            fin_wptr_q <= fin_wptr_d;
            fin_rptr_q <= fin_rptr_d;
            fin_cnt_q  <= fin_cnt_d;
            rin_wptr_q <= rin_wptr_d;
            rin_rptr_q <= rin_rptr_d;
            rin_cnt_q  <= rin_cnt_d;
            credits_q  <= credits_d;
        end
    end

    // Storage needs no reset: occupancy counters alone decide validity.
    always_ff @(posedge clk_i) begin
        fin_mem_q <= fin_mem_d;
        rin_mem_q <= rin_mem_d;
    end

`ifdef BSG_MANYCORE_ENDPOINT_CREDIT_CHECK_EN
    logic credit_err_q, credit_err_d, credit_overflow;

    // A return arriving while every credit is already home means a phantom response.
    assign credit_overflow = rin_enq & ~send_fire & (credits_q == max_credits_lp);

    always_comb begin
        credit_err_d = credit_err_q | credit_overflow;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            credit_err_q <= 1'b0;
        end else begin
            credit_err_q <= credit_err_d;
        end
    end

    assign credit_err_o = reset_n_i & credit_err_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i && credit_overflow) begin
            $error("bsg_manycore_proc_endpoint: credit overflow");
        end
    end
`endif
`else
    assign credit_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_manycore_proc_endpoint.sv
// Directed, table-driven bench for bsg_manycore_proc_endpoint (4 credits, 2-entry FIFOs).
module tb_bsg_manycore_proc_endpoint;

    localparam int X  = 2;
    localparam int Y  = 2;
    localparam int D  = 8;
    localparam int A  = 8;
    localparam int PW = 2 + (D / 8) + A + D + 2 * (X + Y);
    localparam int RW = 2 + D + X + Y;
    localparam int LW = PW + RW + 4;
    localparam int CW = 3;
`ifdef BSG_MANYCORE_ENDPOINT_CREDIT_CHECK_EN
    localparam logic CE = 1'b1;
`else
    localparam logic CE = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          f_v, f_rdy, r_v, r_rdy;
    logic [PW-1:0] f_d;
    logic [RW-1:0] r_d;
    logic [LW-1:0] link_sif_i, link_sif_o;
    logic          in_v_o, in_yumi_i, returning_v_i, returning_ready_o;
    logic [PW-1:0] in_packet_o, out_packet_i;
    logic [RW-1:0] returning_packet_i, returned_packet_o;
    logic          out_v_i, out_ready_o, returned_v_o, returned_yumi_i, credit_err_o;
    logic [CW-1:0] out_credits_o;

    assign link_sif_i = {f_v, f_d, f_rdy, r_v, r_d, r_rdy};

    logic          lo_fwd_v, lo_fwd_rdy, lo_rev_v, lo_rev_rdy;
    logic [PW-1:0] lo_fwd_data;
    logic [RW-1:0] lo_rev_data;
    assign lo_fwd_v    = link_sif_o[LW-1];
    assign lo_fwd_data = link_sif_o[LW-2 -: PW];
    assign lo_fwd_rdy  = link_sif_o[RW+2];
    assign lo_rev_v    = link_sif_o[RW+1];
    assign lo_rev_data = link_sif_o[RW:1];
    assign lo_rev_rdy  = link_sif_o[0];

    bsg_manycore_proc_endpoint #(
        .x_cord_width_p   (X),
        .y_cord_width_p   (Y),
        .data_width_p     (D),
        .addr_width_p     (A),
        .fifo_els_p       (2),
        .max_out_credits_p(4)
    ) dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .link_sif_i        (link_sif_i),
        .link_sif_o        (link_sif_o),
        .in_v_o            (in_v_o),
        .in_packet_o       (in_packet_o),
        .in_yumi_i         (in_yumi_i),
        .returning_v_i     (returning_v_i),
        .returning_packet_i(returning_packet_i),
        .returning_ready_o (returning_ready_o),
        .out_v_i           (out_v_i),
        .out_packet_i      (out_packet_i),
        .out_ready_o       (out_ready_o),
        .returned_v_o      (returned_v_o),
        .returned_packet_o (returned_packet_o),
        .returned_yumi_i   (returned_yumi_i),
        .out_credits_o     (out_credits_o),
        .credit_err_o      (credit_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, fv, rv, lfr, ov, iy, ry;
        logic [7:0] fd, rd;
    } in_t;

    typedef struct {
        logic          inv, rv, ordy, frdy, rrdy, fv, err;
        logic [7:0]    ind, rd;
        logic [CW-1:0] cred;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic in_t I(logic rst_n, logic fv, logic [7:0] fd, logic rv, logic [7:0] rd,
                              logic lfr, logic ov, logic iy, logic ry);
        in_t t;
        t.rst_n = rst_n; t.fv = fv; t.fd = fd; t.rv = rv; t.rd = rd;
        t.lfr = lfr; t.ov = ov; t.iy = iy; t.ry = ry;
        return t;
    endfunction

    function automatic exp_t E(logic inv, logic [7:0] ind, logic rv, logic [7:0] rd, logic ordy,
                               logic [CW-1:0] cred, logic frdy, logic rrdy, logic fv, logic err);
        exp_t t;
        t.inv = inv; t.ind = ind; t.rv = rv; t.rd = rd; t.ordy = ordy;
        t.cred = cred; t.frdy = frdy; t.rrdy = rrdy; t.fv = fv; t.err = err;
        return t;
    endfunction

    task automatic add(input in_t a, input exp_t b);
        vec_t t;
        t.i = a;
        t.e = b;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset_n = 1'b0; f_v = 1'b0; f_d = '0; f_rdy = 1'b1; r_v = 1'b0; r_d = '0; r_rdy = 1'b1;
        in_yumi_i = 1'b0; returning_v_i = 1'b0; returning_packet_i = '0;
        out_v_i = 1'b0; out_packet_i = '0; returned_yumi_i = 1'b0;

        // Credit exhaustion, credit return, FIFO fill/drain, simultaneous fire+return, reset.
        add(I(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0), E(0, 8'h00, 0, 8'h00, 0, 4, 1, 1, 0, 0));
        add(I(1, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0), E(0, 8'h00, 0, 8'h00, 1, 4, 1, 1, 1, 0));
        add(I(1, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0), E(0, 8'h00, 0, 8'h00, 1, 3, 1, 1, 1, 0));
        add(I(1, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0), E(0, 8'h00, 0, 8'h00, 1, 2, 1, 1, 1, 0));
        add(I(1, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0), E(0, 8'h00, 0, 8'h00, 1, 1, 1, 1, 1, 0));
        add(I(1, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0), E(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 0));
        add(I(1, 0, 8'h00, 1, 8'hA5, 1, 1, 0, 0), E(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 0));
        add(I(1, 0, 8'h00, 0, 8'h00, 1, 1, 0, 1), E(0, 8'h00, 1, 8'hA5, 1, 1, 1, 1, 1, 0));
        add(I(1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0), E(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 0));
        add(I(1, 1, 8'h01, 0, 8'h00, 1, 0, 0, 0), E(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 0));
        add(I(1, 1, 8'h02, 0, 8'h00, 1, 0, 0, 0), E(1, 8'h01, 0, 8'h00, 0, 0, 1, 1, 0, 0));
        add(I(1, 1, 8'h03, 0, 8'h00, 1, 0, 0, 0), E(1, 8'h01, 0, 8'h00, 0, 0, 0, 1, 0, 0));
        add(I(1, 1, 8'h03, 0, 8'h00, 1, 0, 1, 0), E(1, 8'h01, 0, 8'h00, 0, 0, 0, 1, 0, 0));
        add(I(1, 1, 8'h03, 0, 8'h00, 1, 0, 1, 0), E(1, 8'h02, 0, 8'h00, 0, 0, 1, 1, 0, 0));
        add(I(1, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0), E(1, 8'h03, 0, 8'h00, 0, 0, 1, 1, 0, 0));
        add(I(1, 0, 8'h00, 1, 8'hAA, 1, 0, 0, 0), E(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 0));
        add(I(1, 0, 8'h00, 1, 8'hBB, 1, 0, 0, 0), E(0, 8'h00, 1, 8'hAA, 1, 1, 1, 1, 0, 0));
        add(I(1, 0, 8'h00, 1, 8'hCC, 1, 0, 0, 0), E(0, 8'h00, 1, 8'hAA, 1, 2, 1, 0, 0, 0));
        add(I(1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1), E(0, 8'h00, 1, 8'hAA, 1, 2, 1, 0, 0, 0));
        add(I(1, 0, 8'h00, 1, 8'hCC, 1, 1, 0, 1), E(0, 8'h00, 1, 8'hBB, 1, 2, 1, 1, 1, 0));
        add(I(1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1), E(0, 8'h00, 1, 8'hCC, 1, 2, 1, 1, 0, 0));
        add(I(1, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0), E(0, 8'h00, 0, 8'h00, 1, 2, 1, 1, 1, 0));
        add(I(1, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0), E(0, 8'h00, 0, 8'h00, 1, 1, 1, 1, 1, 0));
        add(I(1, 0, 8'h00, 1, 8'hDD, 0, 1, 0, 0), E(0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 0));
        add(I(1, 1, 8'h11, 1, 8'hEE, 1, 1, 0, 0), E(0, 8'h00, 1, 8'hDD, 1, 1, 1, 1, 1, 0));
        add(I(1, 1, 8'h22, 0, 8'h00, 1, 0, 0, 0), E(1, 8'h11, 1, 8'hDD, 1, 1, 1, 0, 0, 0));
        add(I(1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0), E(1, 8'h11, 1, 8'hDD, 1, 1, 0, 0, 0, 0));
        add(I(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0), E(0, 8'h00, 0, 8'h00, 0, 4, 1, 1, 0, 0));
        add(I(1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0), E(0, 8'h00, 0, 8'h00, 1, 4, 1, 1, 0, 0));
        add(I(1, 0, 8'h00, 1, 8'h5A, 1, 0, 0, 0), E(0, 8'h00, 0, 8'h00, 1, 4, 1, 1, 0, 0));
        add(I(1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1), E(0, 8'h00, 1, 8'h5A, 1, 4, 1, 1, 0, CE));
        add(I(1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0), E(0, 8'h00, 0, 8'h00, 1, 4, 1, 1, 0, CE));

        #1;
        for (int k = 0; k < vecs.size(); k++) begin
            reset_n         = vecs[k].i.rst_n;
            f_v             = vecs[k].i.fv;
            f_d             = PW'(vecs[k].i.fd);
            r_v             = vecs[k].i.rv;
            r_d             = RW'(vecs[k].i.rd);
            f_rdy           = vecs[k].i.lfr;
            out_v_i         = vecs[k].i.ov;
            out_packet_i    = PW'(k + 16);
            in_yumi_i       = vecs[k].i.iy;
            returned_yumi_i = vecs[k].i.ry;
            #1;
            chk($sformatf("v%0d in_v", k), 32'(in_v_o), 32'(vecs[k].e.inv));
            if (vecs[k].e.inv)
                chk($sformatf("v%0d in_packet", k), 32'(in_packet_o), 32'(vecs[k].e.ind));
            chk($sformatf("v%0d returned_v", k), 32'(returned_v_o), 32'(vecs[k].e.rv));
            if (vecs[k].e.rv)
                chk($sformatf("v%0d returned_pkt", k), 32'(returned_packet_o),
                    32'(vecs[k].e.rd));
            chk($sformatf("v%0d out_ready", k), 32'(out_ready_o), 32'(vecs[k].e.ordy));
            chk($sformatf("v%0d credits", k), 32'(out_credits_o), 32'(vecs[k].e.cred));
            chk($sformatf("v%0d fwd_rdy_o", k), 32'(lo_fwd_rdy), 32'(vecs[k].e.frdy));
            chk($sformatf("v%0d rev_rdy_o", k), 32'(lo_rev_rdy), 32'(vecs[k].e.rrdy));
            chk($sformatf("v%0d fwd_v_o", k), 32'(lo_fwd_v), 32'(vecs[k].e.fv));
            if (vecs[k].e.fv)
                chk($sformatf("v%0d fwd_data_o", k), 32'(lo_fwd_data), k + 16);
            chk($sformatf("v%0d credit_err", k), 32'(credit_err_o), 32'(vecs[k].e.err));
            tick();
        end

        // Idle, credits=4, FIFOs empty. Outgoing paths are combinational pass-throughs.
        f_v = 1'b0; r_v = 1'b0; in_yumi_i = 1'b0; returned_yumi_i = 1'b0;
        out_v_i = 1'b1; out_packet_i = PW'(27'h5A51234);
        #1;
        chk("h1_fwd_v", 32'(lo_fwd_v), 32'd1);
        chk("h1_fwd_data", 32'(lo_fwd_data), 32'h5A51234);
        out_v_i = 1'b0;
        returning_v_i = 1'b1; returning_packet_i = RW'(14'h2ABC); r_rdy = 1'b0;
        #1;
        chk("h2_rev_v", 32'(lo_rev_v), 32'd1);
        chk("h2_rev_data", 32'(lo_rev_data), 32'h2ABC);
        chk("h2_ret_ready_lo", 32'(returning_ready_o), 32'd0);
        r_rdy = 1'b1;
        #1;
        chk("h2_ret_ready_hi", 32'(returning_ready_o), 32'd1);
        returning_v_i = 1'b0;
        tick();

        // Link-to-core latency is exactly one cycle, with no same-cycle bypass.
        f_v = 1'b1; f_d = PW'(8'h77);
        #1;
        chk("h3_no_bypass", 32'(in_v_o), 32'd0);
        tick();
        f_v = 1'b0;
        n = 0;
        while (!in_v_o && n < 4) begin
            tick();
            n++;
        end
        if (!in_v_o) begin
            chk("h3_timeout", 32'(in_v_o), 32'd1);
        end else begin
            chk("h3_latency", n, 0);
            chk("h3_data", 32'(in_packet_o), 32'h77);
        end
        in_yumi_i = 1'b1;
        tick();
        in_yumi_i = 1'b0;
        #1;
        chk("h3_drained", 32'(in_v_o), 32'd0);
        chk("h3_credits", 32'(out_credits_o), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
